gmii_frame_tx: RTL and testbench

Ethernet GMII frame transmitter for the udp_ip_pg test environment. It takes a byte stream with valid/ready/last framing and drives a GMII TX interface (gmiitxd/gmiitxen/gmiitxer). It generates the preamble and SFD, pads short frames, appends the CRC-32 FCS and enforces the inter-frame gap. Its outputs feed the TX side of the GMII-to-RGMII converter directly, in the same clock domain.

---
 rtl/udp_pg_eth_pkg.sv | 33 +++
 rtl/gmii_frame_tx.sv | 122 ++++++++++++
 tb/tb_gmii_frame_tx.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pg_eth_pkg.sv
// Shared Ethernet definitions for the udp_ip_pg frame generator.
// TX state encoding, framing constants and the byte-wide CRC-32 step.
package udp_pg_eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_d8(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: preamble/SFD, padding, CRC-32 FCS and IFG.
// Underrun or a flagged-bad frame ends the frame with one gmiitxer cycle.
module gmii_frame_tx
    import udp_pg_eth_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60,
    parameter bit PAD_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    output logic [7:0] gmiitxd,
    output logic       gmiitxen,
    output logic       gmiitxer,
    output logic       busy
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    tx_state_t   state;
    logic [2:0]  pos;
    logic [10:0] byte_cnt;
    logic [7:0]  ifg_cnt;
    logic [31:0] crc;

    logic [10:0] cnt_inc;
    logic        ifg_done;
    logic        take;

    assign s_tready = (state == DATA) || (state == DROP);
    assign busy     = (state != IDLE);
    assign take     = s_tvalid && s_tready;
    assign cnt_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign ifg_done = (ifg_cnt >= IFG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pos      <= '0;
            byte_cnt <= '0;
            ifg_cnt  <= '0;
            crc      <= CRC_INIT;
            gmiitxd  <= 8'h00;
            gmiitxen <= 1'b0;
            gmiitxer <= 1'b0;
        end else begin
            gmiitxd  <= 8'h00;
            gmiitxen <= 1'b0;
            gmiitxer <= 1'b0;
            unique case (state)
                IDLE: begin
                    pos <= '0;
                    if (s_tvalid) state <= PREAMBLE;
                end
                PREAMBLE: begin
                    gmiitxen <= 1'b1;
                    pos      <= pos + 3'd1;
                    if (pos == 3'd7) begin
                        gmiitxd  <= SFD_BYTE;
                        crc      <= CRC_INIT;
                        byte_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        gmiitxd <= PREAMBLE_BYTE;
                    end
                end
                DATA: begin
                    gmiitxen <= 1'b1;
                    ifg_cnt  <= '0;
                    if (!s_tvalid) begin
                        gmiitxer <= 1'b1;
                        state    <= DROP;
                    end else if (s_tlast && s_tuser) begin
                        gmiitxer <= 1'b1;
                        state    <= IFG;
                    end else begin
                        gmiitxd  <= s_tdata;
                        crc      <= crc32_d8(crc, s_tdata);
                        byte_cnt <= cnt_inc;
                        if (s_tlast) begin
                            if (PAD_EN && (cnt_inc < MIN_CNT)) state <= PAD;
                            else state <= FCS;
                        end
                    end
                end
                PAD: begin
                    gmiitxen <= 1'b1;
                    crc      <= crc32_d8(crc, 8'h00);
                    byte_cnt <= cnt_inc;
                    if (cnt_inc >= MIN_CNT) state <= FCS;
                end
                FCS: begin
                    // pos wrapped to 0 at the SFD; shift the CRC out a byte at a time
                    gmiitxen <= 1'b1;
                    gmiitxd  <= ~crc[7:0];
                    crc      <= {8'h00, crc[31:8]};
                    pos      <= pos + 3'd1;
                    if (pos == 3'd3) begin
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end
                end
                DROP: begin
                    if (!ifg_done) ifg_cnt <= ifg_cnt + 8'd1;
                    if (take && s_tlast) state <= IFG;
                end
                IFG: begin
                    if (ifg_done) state <= IDLE;
                    else ifg_cnt <= ifg_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: padded and unpadded frames,
// aborts, back-to-back spacing and mid-frame reset.
module tb_gmii_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tuser;

    logic       rdy0, rdy1;
    logic [7:0] txd0, txd1;
    logic       en0, en1, er0, er1, busy0, busy1;

    logic       sel;
    logic       rdy_s;
    bit         cap;

    logic [7:0] pay [0:127];
    logic [7:0] exp_q [$];
    logic [7:0] q_d [$];
    bit         q_en [$];
    bit         q_er [$];
    bit         q_busy [$];

    int n_vec = 0;
    int n_bad = 0;

    gmii_frame_tx #(.IFG_BYTES(12), .MIN_PAYLOAD(60), .PAD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy0),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .gmiitxd(txd0), .gmiitxen(en0), .gmiitxer(er0), .busy(busy0)
    );

    gmii_frame_tx #(.IFG_BYTES(12), .MIN_PAYLOAD(60), .PAD_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy1),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .gmiitxd(txd1), .gmiitxen(en1), .gmiitxer(er1), .busy(busy1)
    );

    always #4 clk = ~clk;

    assign rdy_s = sel ? rdy1 : rdy0;

    always @(negedge clk) begin
        if (cap) begin
            q_d.push_back(sel ? txd1 : txd0);
            q_en.push_back(sel ? en1 : en0);
            q_er.push_back(sel ? er1 : er0);
            q_busy.push_back(sel ? busy1 : busy0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c_in,
                                            input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic build_exp(input int len, input bit pad);
        logic [31:0] c;
        int          n;
        exp_q.delete();
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(pay[k]);
            c = crc_bit(c, pay[k]);
        end
        n = len;
        while (pad && n < 60) begin
            exp_q.push_back(8'h00);
            c = crc_bit(c, 8'h00);
            n++;
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    function automatic int first_en(input int from);
        for (int k = from; k < q_en.size(); k++) begin
            if (q_en[k]) return k;
        end
        return -1;
    endfunction

    function automatic int run_len(input int from);
        int n = 0;
        for (int k = from; k >= 0 && k < q_en.size() && q_en[k]; k++) n++;
        return n;
    endfunction

    function automatic int zeros_from(input int from);
        int n = 0;
        for (int k = from; k >= 0 && k < q_en.size() && !q_en[k]; k++) n++;
        return n;
    endfunction

    function automatic int count_en(input int from, input int len);
        int n = 0;
        for (int k = from; k < from + len && k < q_en.size(); k++) begin
            if (q_en[k]) n++;
        end
        return n;
    endfunction

    function automatic int count_er();
        int n = 0;
        foreach (q_er[k]) if (q_er[k]) n++;
        return n;
    endfunction

    task automatic check_bytes(input string tag, input int st, input int n,
                               input int eoff);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_b%0d", tag, k), q_d[st + k], exp_q[eoff + k]);
        end
    endtask

    task automatic start_cap();
        q_d.delete();
        q_en.delete();
        q_er.delete();
        q_busy.delete();
        cap = 1'b1;
    endtask

    // Offer len bytes from pay[]; optionally drop valid for one cycle
    // after stop_at bytes have been accepted.
    task automatic send(input int len, input bit user, input int stop_at);
        int i      = 0;
        int guard  = 0;
        bit gapped = 1'b0;
        bit hs;
        while (i < len && guard < 3000) begin
            if (stop_at > 0 && i == stop_at && !gapped) begin
                s_tvalid = 1'b0;
                gapped   = 1'b1;
            end else begin
                s_tvalid = 1'b1;
            end
            s_tdata = pay[i];
            s_tlast = (i == len - 1);
            s_tuser = user && (i == len - 1);
            @(negedge clk);
            hs = s_tvalid && rdy_s;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        chk("send_done", i, len);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        @(negedge clk);
        while ((busy0 || busy1) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, {busy0, busy1}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        cap = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st, last, st2, ab;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        sel      = 1'b0;
        cap      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en",   en0,   1'b0);
        chk("rst_er",   er0,   1'b0);
        chk("rst_txd",  txd0,  8'h00);
        chk("rst_rdy",  rdy0,  1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_en1",  en1,   1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // "123456789" unpadded: known CRC-32 check value 0xCBF43926
        for (int k = 0; k < 9; k++) pay[k] = 8'h31 + 8'(k);
        exp_q.delete();
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 9; k++) exp_q.push_back(8'h31 + 8'(k));
        exp_q.push_back(8'h26);
        exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'hCB);
        sel = 1'b0;
        start_cap();
        send(9, 1'b0, 0);
        wait_idle("t1_idle");
        st = first_en(0);
        chk("t1_latency", st, 2);
        chk("t1_en_len", run_len(st), 21);
        check_bytes("t1", st, 21, 0);
        last = st + 20;
        chk("t1_ifg_en", count_en(last + 1, 12), 0);
        chk("t1_busy_ifg", q_busy[last + 11], 1'b1);
        chk("t1_busy_idle", q_busy[last + 12], 1'b0);
        chk("t1_er", count_er(), 0);

        // 14-byte payload padded to 60
        for (int k = 0; k < 128; k++) pay[k] = 8'(8'h10 + 3 * k);
        build_exp(14, 1'b1);
        sel = 1'b1;
        start_cap();
        send(14, 1'b0, 0);
        wait_idle("t2_idle");
        st = first_en(0);
        chk("t2_en_len", run_len(st), 72);
        check_bytes("t2", st, 72, 0);
        chk("t2_er", count_er(), 0);

        // underrun after byte 20 of 64
        build_exp(64, 1'b1);
        start_cap();
        send(64, 1'b0, 20);
        wait_idle("t3_idle");
        st = first_en(0);
        chk("t3_en_len", run_len(st), 29);
        check_bytes("t3", st, 28, 0);
        ab = st + 28;
        chk("t3_abort_er", q_er[ab], 1'b1);
        chk("t3_abort_d", q_d[ab], 8'h00);
        chk("t3_after_en", count_en(ab + 1, q_en.size()), 0);
        chk("t3_er_cnt", count_er(), 1);

        // bad frame flagged with s_tuser on s_tlast
        build_exp(64, 1'b1);
        start_cap();
        send(64, 1'b1, 0);
        wait_idle("t4_idle");
        st = first_en(0);
        chk("t4_en_len", run_len(st), 72);
        check_bytes("t4", st, 71, 0);
        ab = st + 71;
        chk("t4_abort_er", q_er[ab], 1'b1);
        chk("t4_abort_d", q_d[ab], 8'h00);
        chk("t4_ifg_en", count_en(ab + 1, 12), 0);
        chk("t4_busy_ifg", q_busy[ab + 11], 1'b1);
        chk("t4_busy_idle", q_busy[ab + 12], 1'b0);
        chk("t4_er_cnt", count_er(), 1);

        // two 64-byte frames back to back
        build_exp(64, 1'b0);
        start_cap();
        send(64, 1'b0, 0);
        send(64, 1'b0, 0);
        wait_idle("t5_idle");
        st = first_en(0);
        chk("t5_len1", run_len(st), 76);
        check_bytes("t5_fcs1", st + 72, 4, 72);
        chk("t5_gap", zeros_from(st + 76), 13);
        st2 = first_en(st + 76);
        chk("t5_pre2", q_d[st2], 8'h55);
        chk("t5_len2", run_len(st2), 76);
        check_bytes("t5_fcs2", st2 + 72, 4, 72);
        chk("t5_er", count_er(), 0);

        // reset in the middle of a payload
        sel      = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hAA;
        s_tlast  = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_pre_busy", busy1, 1'b1);
        @(negedge clk);
        chk("t6_rst_en",   en1,   1'b0);
        chk("t6_rst_er",   er1,   1'b0);
        chk("t6_rst_busy", busy1, 1'b0);
        chk("t6_rst_rdy",  rdy1,  1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_en", en1, 1'b0);
        @(negedge clk);
        chk("t6_start_busy", busy1, 1'b1);
        @(negedge clk);
        chk("t6_start_en",  en1,  1'b1);
        chk("t6_start_txd", txd1, 8'h55);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
